// File: rtl/taillight_seq.sv
// Turn-signal / hazard sequencer for two LAMPS-wide banks, stepped by a DIV prescaler.
// Optional brake overlay: define TAILLIGHT_BRAKE_EN.
module taillight_seq #(
   parameter int LAMPS = 3,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             L,
   input  logic             R,
   input  logic             H,
`ifdef TAILLIGHT_BRAKE_EN
   input  logic             brake,
`endif
   output logic [LAMPS-1:0] left,
   output logic [LAMPS-1:0] right,
   output logic             busy
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW = $clog2(LAMPS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [PW-1:0] PMAX = PW'(LAMPS);

   typedef enum logic [1:0] {
      IDLE,
      LSWEEP,
      RSWEEP,
      HAZ
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [PW-1:0]    p;
   logic [PW-1:0]    p_n;
   logic [CW-1:0]    cnt;
   logic             tick;
   logic             hz;
   logic [LAMPS-1:0] mask;

   assign tick = (cnt == LAST);
   assign hz   = H | (L & R);
   assign busy = (state != IDLE);
   assign mask = ~({LAMPS{1'b1}} << p);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         p     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         p     <= p_n;
         cnt   <= tick ? '0 : cnt + 1'b1;
      end
   end

   // A started sweep always runs to its all-off step; only hazard preempts it.
   always_comb begin
      state_n = state;
      p_n     = p;
      if (tick) begin
         unique case (state)
            IDLE: begin
               if (hz) begin
                  state_n = HAZ;
                  p_n     = '0;
               end else if (L) begin
                  state_n = LSWEEP;
                  p_n     = PW'(1);
               end else if (R) begin
                  state_n = RSWEEP;
                  p_n     = PW'(1);
               end
            end
            LSWEEP, RSWEEP: begin
               if (p == PMAX) begin
                  state_n = IDLE;
                  p_n     = '0;
               end else if (hz) begin
                  state_n = HAZ;
                  p_n     = '0;
               end else begin
                  p_n = p + 1'b1;
               end
            end
            HAZ: begin
               state_n = IDLE;
               p_n     = '0;
            end
         endcase
      end
   end

   always_comb begin
      left  = '0;
      right = '0;
      unique case (state)
         IDLE:   ;
         LSWEEP: left  = mask;
         RSWEEP: right = mask;
         HAZ: begin
            left  = '1;
            right = '1;
         end
      endcase
`ifdef TAILLIGHT_BRAKE_EN
      // Brake lights any bank not busy showing a turn sweep.
      if (brake) begin
         if (state != LSWEEP) left  = '1;
         if (state != RSWEEP) right = '1;
      end
`endif
   end

endmodule

// File: tb/tb_taillight_seq.sv
// Directed bench for taillight_seq: LAMPS=3/DIV=1 and LAMPS=5/DIV=4 instances.
module tb_taillight_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       reset5 = 1'b0;
   logic       l3 = 1'b0, r3 = 1'b0, h3 = 1'b0;
   logic       l5 = 1'b0, r5 = 1'b0, h5 = 1'b0;
   logic [2:0] left3, right3;
   logic [4:0] left5, right5;
   logic       busy3, busy5;
`ifdef TAILLIGHT_BRAKE_EN
   logic       brake3 = 1'b0;
   logic       brake5 = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   taillight_seq #(.LAMPS(3), .DIV(1)) u3 (
      .clk   (clk),
      .reset (reset),
      .L     (l3),
      .R     (r3),
      .H     (h3),
`ifdef TAILLIGHT_BRAKE_EN
      .brake (brake3),
`endif
      .left  (left3),
      .right (right3),
      .busy  (busy3)
   );

   taillight_seq #(.LAMPS(5), .DIV(4)) u5 (
      .clk   (clk),
      .reset (reset5),
      .L     (l5),
      .R     (r5),
      .H     (h5),
`ifdef TAILLIGHT_BRAKE_EN
      .brake (brake5),
`endif
      .left  (left5),
      .right (right5),
      .busy  (busy5)
   );

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] seq_l [8];
   logic [2:0] seq_r [5];
   logic [4:0] seq5  [6];

   initial begin
      seq_l = '{3'b001, 3'b011, 3'b111, 3'b000,
                3'b001, 3'b011, 3'b111, 3'b000};
      seq_r = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
      seq5  = '{5'b00001, 5'b00011, 5'b00111,
                5'b01111, 5'b11111, 5'b00000};

      // reset held two cycles
      #1;
      check("rst_left_async", 8'(left3), 8'h00);
      step();
      step();
      check("rst_left", 8'(left3), 8'h00);
      check("rst_right", 8'(right3), 8'h00);
      check("rst_busy", 8'(busy3), 8'h00);
      check("rst5_left", 8'(left5), 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // held left: repeating 4-step sweep
      l3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("lsweep_left%0d", i), 8'(left3), 8'(seq_l[i]));
         check($sformatf("lsweep_right%0d", i), 8'(right3), 8'h00);
      end
      l3 = 1'b0;
      step();
      check("idle_after_l", 8'(left3), 8'h00);

      // L and R together act as hazard
      l3 = 1'b1;
      r3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("lr_left%0d", i), 8'(left3),
               (i % 2 == 0) ? 8'h07 : 8'h00);
         check($sformatf("lr_right%0d", i), 8'(right3),
               (i % 2 == 0) ? 8'h07 : 8'h00);
         check($sformatf("lr_busy%0d", i), 8'(busy3),
               (i % 2 == 0) ? 8'h01 : 8'h00);
      end
      l3 = 1'b0;
      r3 = 1'b0;

      // one-cycle R pulse still completes the sweep
      r3 = 1'b1;
      step();
      r3 = 1'b0;
      check("rpulse_right0", 8'(right3), 8'(seq_r[0]));
      for (int i = 1; i < 5; i++) begin
         step();
         check($sformatf("rpulse_right%0d", i), 8'(right3), 8'(seq_r[i]));
         check($sformatf("rpulse_left%0d", i), 8'(left3), 8'h00);
      end

      // hazard preempts a left sweep, then left restarts at p=1
      l3 = 1'b1;
      step();
      check("pre_left1", 8'(left3), 8'h01);
      step();
      check("pre_left2", 8'(left3), 8'h03);
      h3 = 1'b1;
      step();
      h3 = 1'b0;
      check("haz_left", 8'(left3), 8'h07);
      check("haz_right", 8'(right3), 8'h07);
      step();
      check("hazoff_left", 8'(left3), 8'h00);
      check("hazoff_right", 8'(right3), 8'h00);
      step();
      check("restart_left", 8'(left3), 8'h01);
      step();
      check("restart_left2", 8'(left3), 8'h03);

      // async reset mid-sweep
      #2;
      reset = 1'b0;
      #1;
      check("midrst_left", 8'(left3), 8'h00);
      check("midrst_busy", 8'(busy3), 8'h00);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("postrst_left", 8'(left3), 8'h01);
      l3 = 1'b0;
      repeat (4) step();
      check("postrst_idle", 8'(left3), 8'h00);

      // DIV=4 instance: off-tick pulse ignored, then stepped sweep
      @(negedge clk);
      reset5 = 1'b1;
      step();
      l5 = 1'b1;
      step();
      l5 = 1'b0;
      step();
      step();
      check("div_pulse_ignored", 8'(left5), 8'h00);
      check("div_pulse_busy", 8'(busy5), 8'h00);
      l5 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         step();
         check($sformatf("div_hold%0d", i), 8'(left5),
               (i == 0) ? 8'h00 : 8'(seq5[i-1]));
         step();
         step();
         check($sformatf("div_left%0d", i), 8'(left5), 8'(seq5[i]));
         check($sformatf("div_right%0d", i), 8'(right5), 8'h00);
      end
      l5 = 1'b0;

`ifdef TAILLIGHT_BRAKE_EN
      // brake overlay on the DIV=1 instance
      repeat (4) step();
      brake3 = 1'b1;
      #1;
      check("brk_idle_left", 8'(left3), 8'h07);
      check("brk_idle_right", 8'(right3), 8'h07);
      check("brk_idle_busy", 8'(busy3), 8'h00);
      l3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("brk_left%0d", i), 8'(left3),
               (i == 3) ? 8'h07 : 8'(seq_l[i]));
         check($sformatf("brk_right%0d", i), 8'(right3), 8'h07);
      end
      l3 = 1'b0;
      brake3 = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/taillight_seq.md
# taillight_seq

Parametrised turn-signal and hazard sequencer driving two banks of LAMPS lamps (left and right), generalising the fixed three-lamp-per-side tail-light FSM. Left/right/hazard requests are sampled on a prescaled step tick, so flash rate is set by DIV rather than the raw clock. Sits between the driver-switch inputs and the lamp drivers; optional brake overlay compiled in by macro.

## Interface
- LAMPS, 3, lamps per side; legal 2..8; bit 0 is the innermost lamp
- DIV, 1, clock cycles per step tick; legal ≥1; DIV=1 means a step every cycle
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- L  input  1  left turn request
- R  input  1  right turn request
- H  input  1  hazard request
- brake  input  1  brake pedal; present only with TAILLIGHT_BRAKE_EN
- left  output  LAMPS  left lamp bank
- right  output  LAMPS  right lamp bank
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Prescaler: counter 0..DIV-1, width max(1,$clog2(DIV)), free-running; tick=1 when count==DIV-1, then wraps to 0. DIV=1 gives tick constantly high.
- State register: {IDLE, LEFT, RIGHT, HAZ}, plus phase counter p (1..LAMPS, width $clog2(LAMPS+1)).
- hz = H | (L & R); simultaneous L and R is treated as hazard.
- Transitions occur only on edges where tick=1. Otherwise state holds.
  - IDLE: hz → HAZ; else L → LEFT p=1; else R → RIGHT p=1; else IDLE.
  - LEFT/RIGHT, p<LAMPS: hz → HAZ (preempts); else p+1. Releasing L/R does not abort; a started sweep completes.
  - LEFT/RIGHT, p==LAMPS: → IDLE (all-off step), regardless of inputs.
  - HAZ: → IDLE.
- Output decode (combinational from state regs, no input path):
  - IDLE: left=0, right=0.
  - LEFT p: left = lowest p bits set ((1<<p)-1), right=0. RIGHT mirrored.
  - HAZ: left and right all ones.
- Held L yields a repeating cycle of LAMPS+1 steps: 001,011,111,000 for LAMPS=3. Held H yields period 2 steps: all on, all off.
- L/R/H are sampled only at tick edges; pulses between ticks are ignored.

## Timing
- Reset asserted: state=IDLE, p=0, prescaler=0, left=0, right=0, busy=0, asynchronously.
- After reset deassertion, first tick at the DIV-th rising edge (count reaches DIV-1 at that edge's preceding cycle; with DIV=1 the first edge).
- Latency: request present at a tick edge → lamps change on that same edge (visible the following cycle); one step = DIV cycles.
- Reset mid-sweep: lamps go dark immediately; after release the sequence restarts from IDLE, not the old phase.
- Hazard arriving mid-sweep: on next tick edge HAZ is entered (all on), then IDLE; if L still held afterwards a fresh sweep starts at p=1.

## Configuration
- TAILLIGHT_BRAKE_EN defined: brake port exists. Combinational overlay, state unaffected, not tick-sampled: when brake=1, any bank not currently showing a LEFT/RIGHT sweep is forced all ones (IDLE: both banks on; LEFT: right on, left sweeps; HAZ: unchanged, all on). Brake therefore holds lamps on during hazard-off steps.
- Not defined: no brake port; outputs exactly as in Operation.

## Test plan
- LAMPS=3, DIV=1: reset low 2 cycles → left=000, right=000, busy=0; release, hold L 8 cycles → left 001,011,111,000,001,011,111,000; right stays 000.
- LAMPS=3, DIV=1: L and R both high → both banks 111,000,111,000; busy=1 on 111 steps, 0 on 000 steps.
- LAMPS=3, DIV=1: R pulsed one cycle then low → right 001,011,111,000 then stays 000 (sweep completes).
- LAMPS=5, DIV=4: hold L → left advances every 4 cycles: 00001,00011,00111,01111,11111,00000; L pulse of 1 cycle placed off-tick → no change.
- LAMPS=3, DIV=1: L held, at left=011 assert H → next 111/111, then 000/000, then left 001 if L still held; reset=0 mid-sweep → outputs 0 without a clock edge.
- TAILLIGHT_BRAKE_EN, LAMPS=3: brake=1 idle → left=right=111; brake=1 with L held → right=111 steady, left sweeps 001,011,111,111 (all-off step shows brake 111).
